// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Groups the PLL/CPU reset handshake signals of pll_reset_sequencer.
//   master: the sequencer (samples pll_locked/force_relock, drives the resets and status).
//   slave : the environment (PLL wrapper, CPU/debug side).
//   Signals:
//     pll_locked    PLL lock indicator, asynchronous to refclk
//     force_relock  single-cycle request to restart the sequence
//     pll_rst       reset to PLL, active high
//     sys_rst       reset to CPU domain, active high
//     ready         high while the CPU clock is qualified and running
//     fail          high after too many failed lock attempts
//     retry_cnt     failed lock attempts in the current sequence
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    modport master (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output retry_cnt
    );

    modport slave (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the CPU clock PLL: pulses the PLL reset, waits for lock with timeout and retry,
//   qualifies lock as stable, then releases the CPU system reset. Loss of lock re-asserts the
//   system reset and restarts the sequence. Single clock domain (refclk).
//   Ports:
//     refclk  reference clock, sole clock of the block
//     rst     asynchronous active-high reset
//     bus     pll_reset_sequencer_if.master (pll_locked, force_relock in;
//             pll_rst, sys_rst, ready, fail, retry_cnt out)
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT     = 4096,
    parameter int unsigned LOCK_STABLE      = 256,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input logic                   refclk,
    input logic                   rst,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CntMaxA = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int unsigned CntMax  = (CntMaxA > RST_PULSE_CYCLES) ? CntMaxA : RST_PULSE_CYCLES;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_t;

    state_t            r_state;
    state_t            w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic [1:0]        r_retry;
    logic [1:0]        w_retry_d;
    logic [1:0]        w_retry_inc;
    logic              r_sync_meta;
    logic              r_lk;
    logic              r_pll_rst;
    logic              r_sys_rst;
    logic              r_ready;
    logic              r_fail;

    // Two-flop synchronizer; every decision below looks at r_lk only.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_lk        <= 1'b0;
        end else begin
            r_sync_meta <= bus.pll_locked;
            r_lk        <= r_sync_meta;
        end
    end

    assign w_retry_inc = r_retry + 2'd1;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_retry_d = r_retry;

        if (bus.force_relock) begin
            w_state_d = StResetPll;
            w_cnt_d   = '0;
            w_retry_d = 2'd0;
        end else begin
            unique case (r_state)
                StResetPll: begin
                    if (r_cnt == CntW'(RST_PULSE_CYCLES - 1)) begin
                        w_state_d = StWaitLock;
                        w_cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (r_lk) begin
                        w_state_d = StStable;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CntW'(LOCK_TIMEOUT - 1)) begin
                        w_retry_d = w_retry_inc;
                        w_cnt_d   = '0;
                        w_state_d = (w_retry_inc == 2'(MAX_RETRIES)) ? StFail : StResetPll;
                    end
                end
                StStable: begin
                    // Lock drop beats a simultaneous qualification completion.
                    if (!r_lk) begin
                        w_state_d = StWaitLock;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CntW'(LOCK_STABLE - 1)) begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                        w_retry_d = 2'd0;
                    end
                end
                StRun: begin
                    w_cnt_d = '0;
                    if (!r_lk) begin
                        w_state_d = StResetPll;
                    end
                end
                StFail: begin
                    w_cnt_d = '0;
                end
                default: begin
                    w_state_d = StResetPll;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as r_state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= StResetPll;
            r_cnt     <= '0;
            r_retry   <= 2'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_retry   <= w_retry_d;
            r_pll_rst <= (w_state_d == StResetPll) || (w_state_d == StFail);
            r_sys_rst <= (w_state_d != StRun);
            r_ready   <= (w_state_d == StRun);
            r_fail    <= (w_state_d == StFail);
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst   = r_sys_rst;
    assign bus.ready     = r_ready;
    assign bus.fail      = r_fail;
    assign bus.retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer. Stimulus pushes each expected output change
//   (cycle stamp + value) into a queue; a monitor pops and compares whenever the output
//   vector {pll_rst, sys_rst, ready, fail, retry_cnt} changes.
module tb_pll_reset_sequencer;

    localparam int TPulse  = 16;
    localparam int TTo     = 4096;
    localparam int TStable = 256;
    localparam int TDec    = 3;   // pll_locked change to first state decision using it

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      name;
    } ev_t;

    logic refclk;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic [5:0] mon_prev = 6'bx;

    pll_reset_sequencer_if u_bus ();

    pll_reset_sequencer u_dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (u_bus)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge refclk);
    endtask

    task automatic expect_ev(input int c, input logic [5:0] v, input string nm);
        ev_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge refclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0",
                     nm, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Monitor: sample just after each falling refclk edge and just after rst rises.
    initial begin
        logic [5:0] cur;
        ev_t        e;
        forever begin
            @(negedge refclk or posedge rst);
            #1;
            cur = {u_bus.pll_rst, u_bus.sys_rst, u_bus.ready, u_bus.fail, u_bus.retry_cnt};
            if (cur !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got %b at cyc %0d, required no change from %b",
                             cur, cyc, mon_prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        failures++;
                        $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                                 e.name, cur, cyc, e.val, e.cyc);
                    end
                end
                mon_prev = cur;
            end
        end
    end

    initial begin
        int c;
        int w;
        int d;
        int e;
        u_bus.pll_locked   = 1'b0;
        u_bus.force_relock = 1'b0;

        // 1: reset, 16-cycle PLL pulse, lock 100 cycles later, 256-cycle qualification
        expect_ev(0, 6'b110000, "reset_values");
        #1 rst = 1'b1;
        tick(5);
        rst = 1'b0;
        c = cyc;
        expect_ev(c + TPulse, 6'b010000, "t1_pll_rst_fall");
        tick(TPulse + 100);
        u_bus.pll_locked = 1'b1;
        c = cyc;
        expect_ev(c + TDec + TStable, 6'b001000, "t1_ready");
        drain(500, "t1");

        // 4: lock lost for 3 cycles in RUN
        tick(20);
        c = cyc;
        u_bus.pll_locked = 1'b0;
        expect_ev(c + 3, 6'b110000, "t4_sys_rst_on");
        expect_ev(c + 3 + TPulse, 6'b010000, "t4_pll_rst_fall");
        expect_ev(c + 3 + TPulse + 1 + TStable, 6'b001000, "t4_ready");
        tick(3);
        u_bus.pll_locked = 1'b1;
        drain(500, "t4");

        // 3: lock drops 100 cycles into STABLE; no release until a full requalification
        tick(20);
        c = cyc;
        u_bus.pll_locked = 1'b0;
        expect_ev(c + 3, 6'b110000, "t3_sys_rst_on");
        expect_ev(c + 3 + TPulse, 6'b010000, "t3_pll_rst_fall");
        tick(39);
        u_bus.pll_locked = 1'b1;
        d = cyc;
        tick(TDec + 100);
        u_bus.pll_locked = 1'b0;
        e = cyc;
        tick(5);
        u_bus.pll_locked = 1'b1;
        expect_ev(e + 5 + TDec + TStable, 6'b001000, "t3_ready");
        drain(500, "t3");
        if (d < 0) $display("unreachable");

        // 6: force_relock in RUN on the same edge lk falls -> one RESET_PLL entry
        tick(20);
        c = cyc;
        expect_ev(c + 3, 6'b110000, "t6_force_reset");
        expect_ev(c + 3 + TPulse, 6'b010000, "t6_single_pulse");
        expect_ev(c + 29 + TDec + TStable, 6'b001000, "t6_ready");
        u_bus.pll_locked = 1'b0;
        tick(2);
        u_bus.force_relock = 1'b1;
        tick(1);
        u_bus.force_relock = 1'b0;
        tick(26);
        u_bus.pll_locked = 1'b1;
        drain(500, "t6");

        // 2: PLL never locks -> three timed-out attempts, FAIL, then force_relock
        tick(20);
        c = cyc;
        u_bus.pll_locked = 1'b0;
        w = c + 3 + TPulse;
        expect_ev(c + 3, 6'b110000, "t2_sys_rst_on");
        expect_ev(w, 6'b010000, "t2_wait1");
        expect_ev(w + TTo, 6'b110001, "t2_retry1");
        expect_ev(w + TTo + TPulse, 6'b010001, "t2_wait2");
        expect_ev(w + 2 * TTo + TPulse, 6'b110010, "t2_retry2");
        expect_ev(w + 2 * TTo + 2 * TPulse, 6'b010010, "t2_wait3");
        expect_ev(w + 3 * TTo + 2 * TPulse, 6'b110111, "t2_fail");
        drain(13000, "t2");
        tick(50);
        c = cyc;
        expect_ev(c + 1, 6'b110000, "t2_force_exit_fail");
        expect_ev(c + 1 + TPulse, 6'b010000, "t2_force_wait");
        u_bus.force_relock = 1'b1;
        tick(1);
        u_bus.force_relock = 1'b0;

        // 5: async rst in WAIT_LOCK with retry_cnt=2
        w = c + 1 + TPulse;
        expect_ev(w + TTo, 6'b110001, "t5_retry1");
        expect_ev(w + TTo + TPulse, 6'b010001, "t5_wait2");
        expect_ev(w + 2 * TTo + TPulse, 6'b110010, "t5_retry2");
        expect_ev(w + 2 * TTo + 2 * TPulse, 6'b010010, "t5_wait3");
        drain(8500, "t5_setup");
        tick(100);
        c = cyc;
        expect_ev(c, 6'b110000, "t5_async_reset");
        #2 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        c = cyc;
        expect_ev(c + TPulse, 6'b010000, "t5_pll_rst_fall");
        tick(TPulse + 5);
        u_bus.pll_locked = 1'b1;
        c = cyc;
        expect_ev(c + TDec + TStable, 6'b001000, "t5_ready");
        drain(500, "t5");

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
